// File: rtl/link_pkg.sv
// Shared definitions for the inter-FPGA drawing link transmitter and receiver.
package link_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, ID, DATA, PARITY, GAP} tx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/link_bit_timer.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while running and flags the terminal count.
module link_bit_timer #(
    parameter int unsigned BIT_PERIOD = 100
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    output logic tick_out
);

    localparam int unsigned CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_out = run_in && (cnt_q == LAST);

    // Wraps to zero on the tick so consecutive bits and packets need no reload.
    always_comb begin
        cnt_d = '0;
        if (run_in && !tick_out) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_channel_link_tx.sv
// Multi-channel framed serial transmitter: snapshots per-pen payloads on a trigger and sends
// each enabled channel as sync, ID, payload, even parity and an idle-high gap.
module multi_channel_link_tx
    import link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 26,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned BIT_PERIOD   = 100,
    parameter int unsigned SYNC_WIDTH   = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = SYNC_WIDTH'(DEFAULT_SYNC_WORD),
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               trigger_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CHANNELS-1:0]            valid_mask_in,
    output logic                               data_out,
    output logic                               busy_out,
    output logic                               done_out,
    output logic                               overrun_out
);

    localparam int unsigned ID_W  = id_width(NUM_CHANNELS);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + SYNC_WIDTH + GAP_BITS + ID_W + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [ID_W-1:0] chan_t;
    typedef logic [NUM_CHANNELS*DATA_WIDTH-1:0] bus_t;
    typedef logic [NUM_CHANNELS-1:0] mask_t;

    localparam cnt_t SYNC_LAST = cnt_t'(SYNC_WIDTH - 1);
    localparam cnt_t ID_LAST   = cnt_t'(ID_W - 1);
    localparam cnt_t DATA_LAST = cnt_t'(DATA_WIDTH - 1);
    localparam cnt_t GAP_LAST  = cnt_t'(GAP_BITS - 1);

    tx_state_t state_q, state_d;
    cnt_t      cnt_q, cnt_d;
    chan_t     chan_q, chan_d;
    bus_t      burst_data_q, burst_data_d;
    mask_t     burst_mask_q, burst_mask_d;
    bus_t      shadow_data_q, shadow_data_d;
    mask_t     shadow_mask_q, shadow_mask_d;
    logic      pending_q, pending_d;
    logic      data_out_q, data_out_d;
    logic      done_q, done_d;
    logic      overrun_q, overrun_d;
    logic      tick;

    logic [ID_W:0]         next_en;
    logic [ID_W:0]         first_en;
    logic [DATA_WIDTH-1:0] payload_d;

    // Lowest enabled channel at or above 'first'; MSB of the result flags that one exists.
    function automatic logic [ID_W:0] find_ch(input mask_t mask, input int first);
        logic [ID_W:0] r;
        r = '0;
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (i >= first && mask[i]) begin
                r = {1'b1, ID_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic line_bit(input tx_state_t st, input cnt_t cnt, input chan_t ch,
                                      input logic [DATA_WIDTH-1:0] pl);
        logic [SYNC_WIDTH-1:0] sw;
        chan_t                 idv;
        logic [DATA_WIDTH-1:0] dv;
        logic                  b;
        sw  = SYNC_WORD << cnt;
        idv = ch << cnt;
        dv  = pl << cnt;
        case (st)
            SYNC:    b = sw[SYNC_WIDTH-1];
            ID:      b = idv[ID_W-1];
            DATA:    b = dv[DATA_WIDTH-1];
            PARITY:  b = ^{ch, pl};
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    link_bit_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_bit_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .run_in  (state_q != IDLE),
        .tick_out(tick)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        chan_d        = chan_q;
        burst_data_d  = burst_data_q;
        burst_mask_d  = burst_mask_q;
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        pending_d     = pending_q;
        done_d        = 1'b0;
        overrun_d     = 1'b0;
        first_en      = '0;
        next_en       = find_ch(burst_mask_q, int'(chan_q) + 1);

        if (state_q == IDLE) begin
            // Only an all-zero request left over from a finished burst can be pending here.
            if (pending_q) begin
                done_d    = 1'b1;
                pending_d = 1'b0;
            end
            if (trigger_in) begin
                if (|valid_mask_in) begin
                    first_en     = find_ch(valid_mask_in, 0);
                    burst_data_d = data_in;
                    burst_mask_d = valid_mask_in;
                    chan_d       = first_en[ID_W-1:0];
                    cnt_d        = '0;
                    state_d      = SYNC;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            if (trigger_in) begin
                shadow_data_d = data_in;
                shadow_mask_d = valid_mask_in;
                pending_d     = 1'b1;
                overrun_d     = pending_q;
            end
            if (tick) begin
                case (state_q)
                    SYNC: begin
                        if (cnt_q == SYNC_LAST) begin
                            cnt_d   = '0;
                            state_d = ID;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ID: begin
                        if (cnt_q == ID_LAST) begin
                            cnt_d   = '0;
                            state_d = DATA;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = '0;
                            state_d = PARITY;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    PARITY: begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                    GAP: begin
                        if (cnt_q != GAP_LAST) begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end else begin
                            cnt_d = '0;
                            if (next_en[ID_W]) begin
                                chan_d  = next_en[ID_W-1:0];
                                state_d = SYNC;
                            end else begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                                // A trigger on this very cycle already sits in pending_d.
                                if (pending_d && |shadow_mask_d) begin
                                    first_en     = find_ch(shadow_mask_d, 0);
                                    burst_data_d = shadow_data_d;
                                    burst_mask_d = shadow_mask_d;
                                    chan_d       = first_en[ID_W-1:0];
                                    pending_d    = 1'b0;
                                    state_d      = SYNC;
                                end
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        payload_d  = DATA_WIDTH'(burst_data_d >> (int'(chan_d) * DATA_WIDTH));
        data_out_d = line_bit(state_d, cnt_d, chan_d, payload_d);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            chan_q        <= '0;
            burst_data_q  <= '0;
            burst_mask_q  <= '0;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            pending_q     <= 1'b0;
            data_out_q    <= 1'b1;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            chan_q        <= chan_d;
            burst_data_q  <= burst_data_d;
            burst_mask_q  <= burst_mask_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            pending_q     <= pending_d;
            data_out_q    <= data_out_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy_out    = (state_q != IDLE);
    assign done_out    = done_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_multi_channel_link_tx.sv
// Bench for multi_channel_link_tx: queue-based packet model checked every cycle, plus directed
// scenarios pinned with hand-computed packets and timings.
module tb_multi_channel_link_tx;

    localparam int BP   = 4;
    localparam int DW   = 26;
    localparam int HIST = 65536;

    localparam logic [37:0] PKT_CH0 = {8'hA5, 1'b0, 26'h2AB_CDEF, 1'b0, 2'b11};
    localparam logic [37:0] PKT_CH1 = {8'hA5, 1'b1, 26'h155_5555, 1'b0, 2'b11};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger_in = 1'b0;
    logic [51:0] data_in = '0;
    logic [1:0]  valid_mask_in = '0;
    logic        data_out, busy_out, done_out, overrun_out;

    always #5 clk = ~clk;

    multi_channel_link_tx #(
        .DATA_WIDTH  (DW),
        .NUM_CHANNELS(2),
        .BIT_PERIOD  (BP)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .trigger_in   (trigger_in),
        .data_in      (data_in),
        .valid_mask_in(valid_mask_in),
        .data_out     (data_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .overrun_out  (overrun_out)
    );

    // ---------------- behavioural model ----------------
    logic        m_bits[$];
    int          m_tmr = 0;
    logic        m_pend = 1'b0;
    logic [51:0] m_sdata = '0;
    logic [1:0]  m_smask = '0;
    logic        m_zero = 1'b0;
    logic        exp_data = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;

    task automatic build(input logic [51:0] d, input logic [1:0] m);
        logic [7:0]  s;
        logic [25:0] pl;
        s = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            if (m[c]) begin
                pl = d[c*DW +: DW];
                for (int i = 7; i >= 0; i--) m_bits.push_back(s[i]);
                m_bits.push_back(c[0]);
                for (int i = DW - 1; i >= 0; i--) m_bits.push_back(pl[i]);
                m_bits.push_back(1'(($countones(pl) + c) % 2));
                m_bits.push_back(1'b1);
                m_bits.push_back(1'b1);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        bit ended;
        if (rst) begin
            m_bits.delete();
            m_tmr = 0; m_pend = 0; m_zero = 0; m_sdata = '0; m_smask = '0;
            exp_done = 0; exp_ovr = 0;
        end else begin
            exp_done = 0;
            exp_ovr  = 0;
            ended    = 0;
            if (m_bits.size() > 0) begin
                m_tmr++;
                if (m_tmr == BP) begin
                    m_tmr = 0;
                    void'(m_bits.pop_front());
                    ended = (m_bits.size() == 0);
                end
                if (trigger_in) begin
                    if (m_pend) exp_ovr = 1;
                    m_pend = 1; m_sdata = data_in; m_smask = valid_mask_in;
                end
                if (ended) begin
                    exp_done = 1;
                    if (m_pend) begin
                        m_pend = 0;
                        if (m_smask != 0) build(m_sdata, m_smask);
                        else m_zero = 1;
                    end
                end
            end else begin
                if (m_zero) begin exp_done = 1; m_zero = 0; end
                if (trigger_in) begin
                    if (valid_mask_in != 0) build(data_in, valid_mask_in);
                    else exp_done = 1;
                end
            end
        end
        exp_data = (m_bits.size() > 0) ? m_bits[0] : 1'b1;
        exp_busy = (m_bits.size() > 0);
    end

    // ---------------- checking ----------------
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   busy_cnt = 0, done_cnt = 0, ovr_cnt = 0, last_done = -1, last_ovr = -1;
    logic data_hist [0:HIST-1];
    logic busy_hist [0:HIST-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc < HIST) begin
                data_hist[cyc] = data_out;
                busy_hist[cyc] = busy_out;
            end
            busy_cnt += int'(busy_out);
            done_cnt += int'(done_out);
            ovr_cnt  += int'(overrun_out);
            if (done_out) last_done = cyc;
            if (overrun_out) last_ovr = cyc;
            check("model_data_out", 64'(data_out), 64'(exp_data));
            check("model_busy_out", 64'(busy_out), 64'(exp_busy));
            check("model_done_out", 64'(done_out), 64'(exp_done));
            check("model_overrun_out", 64'(overrun_out), 64'(exp_ovr));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input logic [51:0] d, input logic [1:0] m);
        trigger_in = 1'b1; data_in = d; valid_mask_in = m;
        tick();
        trigger_in = 1'b0;
    endtask

    function automatic logic [37:0] grab(input int start);
        logic [37:0] r;
        for (int k = 0; k < 38; k++) r[37-k] = data_hist[start + k*BP + 2];
        return r;
    endfunction

    int t, b0, d0, o0, n;
    logic [63:0] rnd;

    initial begin
        fork
            monitor();
        join_none
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_data_out", 64'(data_out), 64'd1);
        check("reset_busy_out", 64'(busy_out), 64'd0);
        check("reset_done_out", 64'(done_out), 64'd0);
        check("reset_overrun_out", 64'(overrun_out), 64'd0);

        // Single channel
        t = cyc; b0 = busy_cnt; d0 = done_cnt;
        send({26'h0, 26'h2AB_CDEF}, 2'b01);
        wait_until(t + 160);
        check("single_packet_bits", 64'(grab(t + 1)), 64'(PKT_CH0));
        check("single_busy_cycles", 64'(busy_cnt - b0), 64'd152);
        check("single_done_count", 64'(done_cnt - d0), 64'd1);
        check("single_done_cycle", 64'(last_done), 64'(t + 153));
        check("single_idle_high", 64'(data_hist[t + 158]), 64'd1);

        // Both channels
        t = cyc; b0 = busy_cnt; d0 = done_cnt;
        send({26'h155_5555, 26'h2AB_CDEF}, 2'b11);
        wait_until(t + 320);
        check("dual_packet0_bits", 64'(grab(t + 1)), 64'(PKT_CH0));
        check("dual_packet1_bits", 64'(grab(t + 153)), 64'(PKT_CH1));
        check("dual_busy_cycles", 64'(busy_cnt - b0), 64'd304);
        check("dual_done_count", 64'(done_cnt - d0), 64'd1);

        // Pending and overrun
        t = cyc; b0 = busy_cnt; d0 = done_cnt; o0 = ovr_cnt;
        send({26'h0, 26'h2AB_CDEF}, 2'b01);
        wait_until(t + 10);
        send({26'h3FF_FFFF, 26'h123_4567}, 2'b11);
        wait_until(t + 20);
        send({26'h155_5555, 26'h0AA_AAAA}, 2'b10);
        wait_until(t + 330);
        check("overrun_count", 64'(ovr_cnt - o0), 64'd1);
        check("overrun_cycle", 64'(last_ovr), 64'(t + 21));
        check("pending_done_count", 64'(done_cnt - d0), 64'd2);
        check("pending_busy_cycles", 64'(busy_cnt - b0), 64'd304);
        check("pending_busy_at_join", 64'(busy_hist[t + 153]), 64'd1);
        check("pending_burst_bits", 64'(grab(t + 153)), 64'(PKT_CH1));

        // Zero mask on idle trigger
        t = cyc; b0 = busy_cnt; d0 = done_cnt;
        send({26'h155_5555, 26'h2AB_CDEF}, 2'b00);
        wait_until(t + 8);
        check("zero_done_count", 64'(done_cnt - d0), 64'd1);
        check("zero_done_cycle", 64'(last_done), 64'(t + 1));
        check("zero_busy_cycles", 64'(busy_cnt - b0), 64'd0);

        // Zero-mask pending request discarded at burst end
        t = cyc; d0 = done_cnt;
        send({26'h0, 26'h2AB_CDEF}, 2'b01);
        wait_until(t + 10);
        send({26'h155_5555, 26'h2AB_CDEF}, 2'b00);
        wait_until(t + 170);
        check("zero_pend_done_count", 64'(done_cnt - d0), 64'd2);
        check("zero_pend_last_done", 64'(last_done), 64'(t + 154));

        // Async reset mid-packet
        t = cyc;
        send(52'h0, 2'b01);
        wait_until(t + 60);
        check("pre_reset_data_low", 64'(data_out), 64'd0);
        rst = 1'b1;
        #1;
        check("async_reset_data_out", 64'(data_out), 64'd1);
        check("async_reset_busy_out", 64'(busy_out), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        b0 = busy_cnt;
        repeat (20) tick();
        check("post_reset_quiet", 64'(busy_cnt - b0), 64'd0);
        t = cyc;
        send({26'h0, 26'h2AB_CDEF}, 2'b01);
        wait_until(t + 160);
        check("post_reset_packet", 64'(grab(t + 1)), 64'(PKT_CH0));

        // Trigger on the final gap cycle
        t = cyc; b0 = busy_cnt; d0 = done_cnt; o0 = ovr_cnt;
        send({26'h0, 26'h2AB_CDEF}, 2'b01);
        wait_until(t + 152);
        send({26'h155_5555, 26'h0}, 2'b10);
        wait_until(t + 320);
        check("boundary_overrun", 64'(ovr_cnt - o0), 64'd0);
        check("boundary_busy_cycles", 64'(busy_cnt - b0), 64'd304);
        check("boundary_done_count", 64'(done_cnt - d0), 64'd2);
        check("boundary_busy_at_join", 64'(busy_hist[t + 153]), 64'd1);
        check("boundary_second_bits", 64'(grab(t + 153)), 64'(PKT_CH1));

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 330)) tick();
            rnd = {$urandom, $urandom};
            send(rnd[51:0], 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 200)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        n = 0;
        while (busy_out && n < 3000) begin
            tick();
            n++;
        end
        check("final_idle_timeout", 64'(busy_out), 64'd0);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
